// File: rtl/rob_commit_pkg.sv
// Shared ROB widths, tag/register/data types, entry type codes and entry layout.
package rob_commit_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_POS_W = 4;
  localparam int DATA_W    = 32;
  localparam int REG_POS_W = 5;

  typedef logic [ROB_POS_W-1:0] rob_pos_t;
  typedef logic [ROB_POS_W:0]   rob_cnt_t;
  typedef logic [REG_POS_W-1:0] reg_pos_t;
  typedef logic [DATA_W-1:0]    data_t;

  localparam rob_pos_t ZERO_ROB = '0;
  localparam reg_pos_t ZERO_REG = '0;

  // Code 3 is not produced by the decoder and retires as a normal op.
  typedef enum logic [1:0] {
    ROB_NORMAL = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_RSVD   = 2'd3
  } rob_type_e;

  typedef struct packed {
    reg_pos_t  dest_reg;
    rob_type_e rob_type;
    logic      pred_taken;
    data_t     alt_pc;
    data_t     value;
    logic      taken;
  } rob_entry_t;

  typedef struct packed {
    logic  ready;
    data_t value;
  } query_t;

endpackage

// File: rtl/rob_commit.sv
// In-order retirement buffer: one issue and one commit per cycle; results written at edge N retire at N+1.
// Commit/flush outputs are registered; issue is refused while full or during the flush cycle.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           in_issue_flag,
  input  logic [4:0]     in_issue_dest_reg,
  input  logic [1:0]     in_issue_type,
  input  logic           in_issue_pred_taken,
  input  logic [31:0]    in_issue_alt_pc,
  output logic [3:0]     out_issue_rob,
  output logic           out_rob_full,
  input  logic [3:0]     in_query_rob1,
  input  logic [3:0]     in_query_rob2,
  output logic           out_query_ready1,
  output logic           out_query_ready2,
  output logic [31:0]    out_query_value1,
  output logic [31:0]    out_query_value2,
  input  logic           in_alu_flag,
  input  logic [3:0]     in_alu_rob,
  input  logic [31:0]    in_alu_value,
  input  logic           in_alu_taken,
  input  logic           in_lsb_flag,
  input  logic [3:0]     in_lsb_rob,
  input  logic [31:0]    in_lsb_value,
  output logic [4:0]     out_commit_reg,
  output logic [3:0]     out_commit_rob,
  output logic [31:0]    out_commit_value,
  output logic           out_commit_store,
  output logic           out_xbp,
  output logic [31:0]    out_xbp_pc
);

  rob_pos_t            head, tail;
  rob_cnt_t            count;
  logic [ROB_SIZE-1:0] ready_q;
  rob_entry_t          ent_q [ROB_SIZE];

  rob_entry_t head_ent;
  logic       commit_en, mispredict, issue_en, alu_wb, lsb_wb;

  assign head_ent     = ent_q[head];
  assign commit_en    = (count != '0) && ready_q[head];
  assign mispredict   = commit_en && (head_ent.rob_type == ROB_BRANCH) &&
                        (head_ent.taken != head_ent.pred_taken);
  assign out_rob_full = (count == rob_cnt_t'(ROB_SIZE));
  assign out_issue_rob = tail;

  // The cycle after a flush belongs to the redirect: nothing new is accepted.
  assign issue_en = in_issue_flag && !out_rob_full && !out_xbp;
  assign alu_wb   = in_alu_flag && !out_xbp;
  assign lsb_wb   = in_lsb_flag && !out_xbp;

  function automatic query_t query(input rob_pos_t tag);
    query_t q;
    q.ready = ready_q[tag];
    q.value = ent_q[tag].value;
    if (lsb_wb && (in_lsb_rob == tag)) begin
      q.ready = 1'b1;
      q.value = in_lsb_value;
    end
    if (alu_wb && (in_alu_rob == tag)) begin
      q.ready = 1'b1;
      q.value = in_alu_value;
    end
    return q;
  endfunction

  assign {out_query_ready1, out_query_value1} = query(in_query_rob1);
  assign {out_query_ready2, out_query_value2} = query(in_query_rob2);

  always_ff @(posedge clk) begin
    if (rst) begin
      head             <= ZERO_ROB;
      tail             <= ZERO_ROB;
      count            <= '0;
      ready_q          <= '0;
      out_commit_reg   <= ZERO_REG;
      out_commit_rob   <= ZERO_ROB;
      out_commit_value <= '0;
      out_commit_store <= 1'b0;
      out_xbp          <= 1'b0;
      out_xbp_pc       <= '0;
    end else if (!rdy) begin
      out_commit_reg   <= ZERO_REG;
      out_commit_store <= 1'b0;
      out_xbp          <= 1'b0;
    end else begin
      out_commit_reg   <= ZERO_REG;
      out_commit_store <= 1'b0;
      out_xbp          <= 1'b0;
      if (commit_en) begin
        out_commit_rob   <= head;
        out_commit_value <= head_ent.value;
        case (head_ent.rob_type)
          ROB_STORE:  out_commit_store <= 1'b1;
          ROB_BRANCH: if (mispredict) begin
            out_xbp    <= 1'b1;
            out_xbp_pc <= head_ent.alt_pc;
          end
          default:    out_commit_reg <= head_ent.dest_reg;
        endcase
      end
      if (mispredict) begin
        head    <= ZERO_ROB;
        tail    <= ZERO_ROB;
        count   <= '0;
        ready_q <= '0;
      end else begin
        // ALU is written last so it wins a (protocol-violating) tag collision.
        if (lsb_wb) begin
          ent_q[in_lsb_rob].value <= in_lsb_value;
          ready_q[in_lsb_rob]     <= 1'b1;
        end
        if (alu_wb) begin
          ent_q[in_alu_rob].value <= in_alu_value;
          ent_q[in_alu_rob].taken <= in_alu_taken;
          ready_q[in_alu_rob]     <= 1'b1;
        end
        if (issue_en) begin
          ent_q[tail].dest_reg   <= in_issue_dest_reg;
          ent_q[tail].rob_type   <= rob_type_e'(in_issue_type);
          ent_q[tail].pred_taken <= in_issue_pred_taken;
          ent_q[tail].alt_pc     <= in_issue_alt_pc;
          ent_q[tail].taken      <= 1'b0;
          ready_q[tail]          <= 1'b0;
        end
        head  <= head + rob_pos_t'(commit_en);
        tail  <= tail + rob_pos_t'(issue_en);
        count <= count + rob_cnt_t'(issue_en) - rob_cnt_t'(commit_en);
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Scenario tasks with fixed expectations plus a randomized run against a queue-based program-order model.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_issue_flag;
  logic [4:0]  in_issue_dest_reg;
  logic [1:0]  in_issue_type;
  logic        in_issue_pred_taken;
  logic [31:0] in_issue_alt_pc;
  logic [3:0]  out_issue_rob;
  logic        out_rob_full;
  logic [3:0]  in_query_rob1, in_query_rob2;
  logic        out_query_ready1, out_query_ready2;
  logic [31:0] out_query_value1, out_query_value2;
  logic        in_alu_flag;
  logic [3:0]  in_alu_rob;
  logic [31:0] in_alu_value;
  logic        in_alu_taken;
  logic        in_lsb_flag;
  logic [3:0]  in_lsb_rob;
  logic [31:0] in_lsb_value;
  logic [4:0]  out_commit_reg;
  logic [3:0]  out_commit_rob;
  logic [31:0] out_commit_value;
  logic        out_commit_store;
  logic        out_xbp;
  logic [31:0] out_xbp_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_issue_flag(in_issue_flag), .in_issue_dest_reg(in_issue_dest_reg),
    .in_issue_type(in_issue_type), .in_issue_pred_taken(in_issue_pred_taken),
    .in_issue_alt_pc(in_issue_alt_pc), .out_issue_rob(out_issue_rob),
    .out_rob_full(out_rob_full), .in_query_rob1(in_query_rob1),
    .in_query_rob2(in_query_rob2), .out_query_ready1(out_query_ready1),
    .out_query_ready2(out_query_ready2), .out_query_value1(out_query_value1),
    .out_query_value2(out_query_value2), .in_alu_flag(in_alu_flag),
    .in_alu_rob(in_alu_rob), .in_alu_value(in_alu_value), .in_alu_taken(in_alu_taken),
    .in_lsb_flag(in_lsb_flag), .in_lsb_rob(in_lsb_rob), .in_lsb_value(in_lsb_value),
    .out_commit_reg(out_commit_reg), .out_commit_rob(out_commit_rob),
    .out_commit_value(out_commit_value), .out_commit_store(out_commit_store),
    .out_xbp(out_xbp), .out_xbp_pc(out_xbp_pc)
  );

  // Reference model: live instructions oldest-first, each carrying its tag.
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  dest;
    logic [1:0]  typ;
    logic        pred;
    logic [31:0] alt;
    logic [31:0] value;
    logic        taken;
    logic        ready;
  } ment_t;

  ment_t       mq[$];
  logic [3:0]  m_tail = '0;
  logic        m_xbp = 1'b0;
  logic        e_commit, e_store, e_xbp;
  logic [4:0]  e_reg;
  logic [3:0]  e_rob;
  logic [31:0] e_value, e_pc;

  function automatic void model_edge();
    bit    full  = (mq.size() == ROB_SIZE);
    bit    flush = 0;
    ment_t t;
    e_commit = 0; e_store = 0; e_xbp = 0; e_reg = '0;
    if (rst) begin
      mq.delete(); m_tail = '0; m_xbp = 0;
      return;
    end
    if (!rdy) begin
      m_xbp = 0;
      return;
    end
    if (mq.size() > 0 && mq[0].ready) begin
      e_commit = 1; e_rob = mq[0].tag; e_value = mq[0].value;
      if (mq[0].typ == 2'd2) e_store = 1;
      else if (mq[0].typ == 2'd1) begin
        if (mq[0].taken != mq[0].pred) begin
          e_xbp = 1; e_pc = mq[0].alt; flush = 1;
        end
      end else e_reg = mq[0].dest;
    end
    if (flush) begin
      mq.delete(); m_tail = '0;
    end else begin
      if (!m_xbp) begin
        foreach (mq[i]) begin
          t = mq[i];
          if (in_lsb_flag && t.tag == in_lsb_rob) begin t.value = in_lsb_value; t.ready = 1; end
          if (in_alu_flag && t.tag == in_alu_rob) begin
            t.value = in_alu_value; t.taken = in_alu_taken; t.ready = 1;
          end
          mq[i] = t;
        end
      end
      if (e_commit) void'(mq.pop_front());
      if (!m_xbp && in_issue_flag && !full) begin
        t.tag = m_tail; t.dest = in_issue_dest_reg; t.typ = in_issue_type;
        t.pred = in_issue_pred_taken; t.alt = in_issue_alt_pc;
        t.value = '0; t.taken = 0; t.ready = 0;
        mq.push_back(t);
        m_tail = m_tail + 4'd1;
      end
    end
    m_xbp = e_xbp;
  endfunction

  task automatic drive_idle();
    rst = 0; rdy = 1;
    in_issue_flag = 0; in_issue_dest_reg = '0; in_issue_type = '0;
    in_issue_pred_taken = 0; in_issue_alt_pc = '0;
    in_query_rob1 = '0; in_query_rob2 = '0;
    in_alu_flag = 0; in_alu_rob = '0; in_alu_value = '0; in_alu_taken = 0;
    in_lsb_flag = 0; in_lsb_rob = '0; in_lsb_value = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      in_issue_flag = 1; in_issue_dest_reg = 5'(i + 1);
      tick();
    end
    drive_idle();
    in_alu_flag = 1; in_alu_rob = 4'd0; in_alu_value = 32'h55;
    tick();
    drive_idle();
    apply_reset();
    checks++; if (out_issue_rob !== 4'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", out_issue_rob); end
    checks++; if (out_rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", out_rob_full); end
    checks++; if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL reset_commit_reg got %0d want 0", out_commit_reg); end
    checks++; if (out_commit_rob !== 4'd0) begin errors++; $display("FAIL reset_commit_rob got %0d want 0", out_commit_rob); end
    checks++; if (out_commit_value !== 32'd0) begin errors++; $display("FAIL reset_commit_value got %h want 0", out_commit_value); end
    checks++; if (out_commit_store !== 1'b0) begin errors++; $display("FAIL reset_store got %0b want 0", out_commit_store); end
    checks++; if (out_xbp !== 1'b0) begin errors++; $display("FAIL reset_xbp got %0b want 0", out_xbp); end
    checks++; if (out_xbp_pc !== 32'd0) begin errors++; $display("FAIL reset_xbp_pc got %h want 0", out_xbp_pc); end
    // Nothing from before the reset may retire.
    tick();
    checks++; if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL reset_no_commit got %0d want 0", out_commit_reg); end
  endtask

  task automatic test_inorder();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'(i + 1);
      #1;
      checks++; if (out_issue_rob !== 4'(i)) begin errors++; $display("FAIL inorder_tag%0d got %0d want %0d", i, out_issue_rob, i); end
      tick();
    end
    drive_idle(); in_lsb_flag = 1; in_lsb_rob = 4'd1; in_lsb_value = 32'd5;
    tick();
    checks++; if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL inorder_hold got %0d want 0", out_commit_reg); end
    drive_idle(); in_alu_flag = 1; in_alu_rob = 4'd0; in_alu_value = 32'd7;
    tick();
    checks++; if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL inorder_wb_lat got %0d want 0", out_commit_reg); end
    drive_idle();
    tick();
    checks++; if ({out_commit_reg, out_commit_rob, out_commit_value} !== {5'd1, 4'd0, 32'd7}) begin
      errors++; $display("FAIL inorder_c0 got reg %0d rob %0d val %0d want 1 0 7", out_commit_reg, out_commit_rob, out_commit_value); end
    tick();
    checks++; if ({out_commit_reg, out_commit_rob, out_commit_value} !== {5'd2, 4'd1, 32'd5}) begin
      errors++; $display("FAIL inorder_c1 got reg %0d rob %0d val %0d want 2 1 5", out_commit_reg, out_commit_rob, out_commit_value); end
    tick();
    checks++; if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL inorder_x3_pending got %0d want 0", out_commit_reg); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < ROB_SIZE; i++) begin
      drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'(i + 3);
      tick();
    end
    checks++; if (out_rob_full !== 1'b1) begin errors++; $display("FAIL full_set got %0b want 1", out_rob_full); end
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd9;
    tick();
    checks++; if (out_issue_rob !== 4'd0) begin errors++; $display("FAIL full_ignored_tail got %0d want 0", out_issue_rob); end
    drive_idle(); in_alu_flag = 1; in_alu_rob = 4'd0; in_alu_value = 32'h11;
    tick();
    // Issue on the freeing edge is still refused: fullness is judged before the commit.
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd9;
    #1;
    checks++; if (out_rob_full !== 1'b1) begin errors++; $display("FAIL full_before_commit got %0b want 1", out_rob_full); end
    tick();
    checks++; if ({out_commit_reg, out_commit_rob, out_commit_value} !== {5'd3, 4'd0, 32'h11}) begin
      errors++; $display("FAIL full_commit got reg %0d rob %0d val %h want 3 0 11", out_commit_reg, out_commit_rob, out_commit_value); end
    checks++; if (out_rob_full !== 1'b0) begin errors++; $display("FAIL full_drop got %0b want 0", out_rob_full); end
    checks++; if (out_issue_rob !== 4'd0) begin errors++; $display("FAIL full_next_tag got %0d want 0", out_issue_rob); end
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd4;
    tick();
    checks++; if (out_rob_full !== 1'b1 || out_issue_rob !== 4'd1) begin
      errors++; $display("FAIL full_refill got full %0b tag %0d want 1 1", out_rob_full, out_issue_rob); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int k = 0; k <= 21; k++) begin
      drive_idle();
      if (k <= 20) begin
        in_issue_flag = 1; in_issue_dest_reg = 5'((k % 31) + 1);
        #1;
        checks++; if (out_issue_rob !== 4'(k % 16)) begin
          errors++; $display("FAIL wrap_tag k=%0d got %0d want %0d", k, out_issue_rob, k % 16); end
      end
      if (k >= 1) begin
        in_alu_flag = 1; in_alu_rob = 4'((k - 1) % 16); in_alu_value = 32'h1000 + 32'(k - 1);
      end
      tick();
      if (k >= 2) begin
        checks++;
        if ({out_commit_reg, out_commit_rob, out_commit_value} !==
            {5'(((k - 2) % 31) + 1), 4'((k - 2) % 16), 32'h1000 + 32'(k - 2)}) begin
          errors++; $display("FAIL wrap_commit k=%0d got reg %0d rob %0d val %h want %0d %0d %h", k,
            out_commit_reg, out_commit_rob, out_commit_value, ((k - 2) % 31) + 1, (k - 2) % 16, 32'h1000 + 32'(k - 2));
        end
      end
    end
  endtask

  task automatic test_mispredict();
    apply_reset();
    drive_idle(); in_issue_flag = 1; in_issue_type = 2'd1; in_issue_pred_taken = 0; in_issue_alt_pc = 32'h100;
    tick();
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd4; tick();
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd5; tick();
    drive_idle(); in_alu_flag = 1; in_alu_rob = 4'd0; in_alu_taken = 1;
    in_lsb_flag = 1; in_lsb_rob = 4'd1; in_lsb_value = 32'h44;
    tick();
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd6;
    tick();
    checks++; if (out_xbp !== 1'b1 || out_xbp_pc !== 32'h100) begin
      errors++; $display("FAIL xbp_pulse got xbp %0b pc %h want 1 100", out_xbp, out_xbp_pc); end
    checks++; if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL xbp_reg got %0d want 0", out_commit_reg); end
    checks++; if (out_issue_rob !== 4'd0) begin errors++; $display("FAIL xbp_tail got %0d want 0", out_issue_rob); end
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd7;
    tick();
    checks++; if (out_xbp !== 1'b0 || out_issue_rob !== 4'd0) begin
      errors++; $display("FAIL xbp_after got xbp %0b tag %0d want 0 0", out_xbp, out_issue_rob); end
    checks++; if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL xbp_flushed_commit got %0d want 0", out_commit_reg); end
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd8;
    tick();
    checks++; if (out_issue_rob !== 4'd1) begin errors++; $display("FAIL xbp_reissue got %0d want 1", out_issue_rob); end
  endtask

  task automatic test_query_fwd();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'(i + 1); tick();
    end
    drive_idle();
    in_lsb_flag = 1; in_lsb_rob = 4'd3; in_lsb_value = 32'hDEADBEEF; in_query_rob1 = 4'd3;
    in_alu_flag = 1; in_alu_rob = 4'd1; in_alu_value = 32'hA1A1; in_query_rob2 = 4'd1;
    #1;
    checks++; if (out_query_ready1 !== 1'b1 || out_query_value1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL query_lsb_fwd got %0b %h want 1 deadbeef", out_query_ready1, out_query_value1); end
    checks++; if (out_query_ready2 !== 1'b1 || out_query_value2 !== 32'hA1A1) begin
      errors++; $display("FAIL query_alu_fwd got %0b %h want 1 a1a1", out_query_ready2, out_query_value2); end
    in_lsb_rob = 4'd1; in_lsb_value = 32'hB2B2;
    #1;
    checks++; if (out_query_value2 !== 32'hA1A1) begin
      errors++; $display("FAIL query_alu_priority got %h want a1a1", out_query_value2); end
    in_lsb_rob = 4'd3; in_lsb_value = 32'hDEADBEEF;
    tick();
    drive_idle(); in_query_rob1 = 4'd3; in_query_rob2 = 4'd2;
    #1;
    checks++; if (out_query_ready1 !== 1'b1 || out_query_value1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL query_stored got %0b %h want 1 deadbeef", out_query_ready1, out_query_value1); end
    checks++; if (out_query_ready2 !== 1'b0) begin errors++; $display("FAIL query_not_ready got %0b want 0", out_query_ready2); end
  endtask

  task automatic test_store();
    apply_reset();
    drive_idle(); in_issue_flag = 1; in_issue_dest_reg = 5'd6; tick();
    drive_idle(); in_issue_flag = 1; in_issue_type = 2'd2; tick();
    drive_idle(); in_alu_flag = 1; in_alu_rob = 4'd0; in_alu_value = 32'h22;
    in_lsb_flag = 1; in_lsb_rob = 4'd1; tick();
    drive_idle(); tick();
    checks++; if (out_commit_reg !== 5'd6 || out_commit_store !== 1'b0) begin
      errors++; $display("FAIL store_prev got reg %0d st %0b want 6 0", out_commit_reg, out_commit_store); end
    tick();
    checks++; if ({out_commit_store, out_commit_reg, out_commit_rob} !== {1'b1, 5'd0, 4'd1}) begin
      errors++; $display("FAIL store_commit got st %0b reg %0d rob %0d want 1 0 1", out_commit_store, out_commit_reg, out_commit_rob); end
    tick();
    checks++; if (out_commit_store !== 1'b0) begin errors++; $display("FAIL store_pulse got %0b want 0", out_commit_store); end
  endtask

  task automatic test_random();
    int    pend[$];
    int    ai, li;
    ment_t t;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      drive_idle();
      rdy = ($urandom_range(9) != 0);
      if ($urandom_range(9) < 6) begin
        in_issue_flag = 1; in_issue_type = 2'($urandom_range(3));
        in_issue_dest_reg = (in_issue_type == 2'd1 || in_issue_type == 2'd2) ? 5'd0 : 5'($urandom_range(31));
        in_issue_pred_taken = 1'($urandom_range(1)); in_issue_alt_pc = $urandom;
      end
      pend.delete();
      foreach (mq[i]) if (!mq[i].ready) pend.push_back(i);
      ai = -1;
      if (pend.size() > 0 && $urandom_range(1) == 1) begin
        ai = $urandom_range(pend.size() - 1);
        t = mq[pend[ai]];
        in_alu_flag = 1; in_alu_rob = t.tag; in_alu_value = $urandom;
        in_alu_taken = (t.typ == 2'd1) ? (($urandom_range(3) == 0) ? ~t.pred : t.pred) : 1'($urandom_range(1));
      end
      if (pend.size() > 1 && $urandom_range(1) == 1) begin
        li = (ai < 0) ? $urandom_range(pend.size() - 1) : (ai + 1) % pend.size();
        in_lsb_flag = 1; in_lsb_rob = mq[pend[li]].tag; in_lsb_value = $urandom;
      end
      if (mq.size() > 0) begin
        in_query_rob1 = mq[$urandom_range(mq.size() - 1)].tag;
        in_query_rob2 = mq[$urandom_range(mq.size() - 1)].tag;
      end
      #1;
      checks++; if (out_issue_rob !== m_tail) begin
        errors++; $display("FAIL rnd_tag c=%0d got %0d want %0d", c, out_issue_rob, m_tail); end
      checks++; if (out_rob_full !== (mq.size() == ROB_SIZE)) begin
        errors++; $display("FAIL rnd_full c=%0d got %0b want %0b", c, out_rob_full, mq.size() == ROB_SIZE); end
      if (rdy && mq.size() > 0) begin
        foreach (mq[i]) begin
          if (mq[i].tag == in_query_rob1) begin
            t = mq[i];
            if (in_lsb_flag && in_lsb_rob == t.tag) begin t.ready = 1; t.value = in_lsb_value; end
            if (in_alu_flag && in_alu_rob == t.tag) begin t.ready = 1; t.value = in_alu_value; end
            checks++;
            if (out_query_ready1 !== t.ready || (t.ready && out_query_value1 !== t.value)) begin
              errors++; $display("FAIL rnd_query c=%0d got %0b %h want %0b %h", c, out_query_ready1, out_query_value1, t.ready, t.value);
            end
          end
        end
      end
      tick();
      checks++;
      if ({out_commit_reg, out_commit_store, out_xbp} !== {e_reg, e_store, e_xbp}) begin
        errors++; $display("FAIL rnd_commit c=%0d got reg %0d st %0b xbp %0b want %0d %0b %0b", c,
          out_commit_reg, out_commit_store, out_xbp, e_reg, e_store, e_xbp);
      end
      if (e_commit) begin
        checks++;
        if (out_commit_rob !== e_rob || out_commit_value !== e_value) begin
          errors++; $display("FAIL rnd_commit_data c=%0d got rob %0d val %h want %0d %h", c, out_commit_rob, out_commit_value, e_rob, e_value);
        end
      end
      if (e_xbp) begin
        checks++;
        if (out_xbp_pc !== e_pc) begin errors++; $display("FAIL rnd_xbp_pc c=%0d got %h want %h", c, out_xbp_pc, e_pc); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst = 1;
    test_reset();
    test_inorder();
    test_full();
    test_wrap();
    test_mispredict();
    test_query_fwd();
    test_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
